// File: rtl/sum_pkg.sv
// Shared definitions for the operand loader and the N-operand, K-cycle summer.
package sum_pkg;

    // Default geometry, kept in one place so loader and summer agree
    localparam int SUM_N = 10;
    localparam int SUM_W = 5;
    localparam int SUM_K = 4;

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/sum_window_timer.sv
// Summation window timer: load starts a K-1 countdown, and done pulses
// for exactly one cycle in the last cycle of the window.
module sum_window_timer
    import sum_pkg::*;
#(
    parameter int K = SUM_K
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CNTW = (K > 1) ? $clog2(K) : 1;

    logic [CNTW-1:0] cnt;
    logic            active;

    // Count down after load; done is registered so that it rises exactly when cnt reaches zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else if (load) begin
            cnt    <= CNTW'(K - 1);
            active <= 1'b1;
            done   <= (K == 1);
        end else if (active) begin
            if (cnt != '0) begin
                cnt <= cnt - CNTW'(1);
            end
            done <= (cnt == CNTW'(1));
            if (done) begin
                active <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/sum_operand_loader.sv
// Operand loader feeding the N-operand summer: collects N serial operands
// into a slot bank, pulses start_o, then holds the bank for the K-cycle window.
// Optional feature macro: SUM_LOADER_ABORT_EN adds abort_i to discard a partial batch.
module sum_operand_loader
    import sum_pkg::*;
#(
    parameter int N  = SUM_N,
    parameter int W  = SUM_W,
    parameter int K  = SUM_K,
    parameter int CW = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst,
`ifdef SUM_LOADER_ABORT_EN
    input  logic           abort_i,
`endif
    input  logic           in_valid,
    input  logic [W-1:0]   in_data,
    output logic           in_ready,
    output logic [N*W-1:0] nums_o,
    output logic           start_o,
    output logic           busy_o,
    output logic           batch_done,
    output logic [CW-1:0]  fill_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    loader_state_t  state;
    logic [IW-1:0]  idx;
    logic           window_done;

    // Window timer is loaded during the single LAUNCH cycle
    sum_window_timer #(.K(K)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (state == S_LAUNCH),
        .done (window_done)
    );

    assign batch_done = window_done;

    // Loader FSM with slot bank and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FILL;
            idx      <= '0;
            fill_cnt <= '0;
            nums_o   <= '0;
            in_ready <= 1'b1;
            start_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
`ifdef SUM_LOADER_ABORT_EN
                    if (abort_i) begin
                        idx      <= '0;
                        fill_cnt <= '0;
                        nums_o   <= '0;
                    end else
`endif
                    if (in_valid && in_ready) begin
                        nums_o[idx*W +: W] <= in_data;
                        if (idx == IW'(N - 1)) begin
                            idx      <= '0;
                            fill_cnt <= CW'(N);
                            state    <= S_LAUNCH;
                            in_ready <= 1'b0;
                            start_o  <= 1'b1;
                            busy_o   <= 1'b1;
                        end else begin
                            idx      <= idx + IW'(1);
                            fill_cnt <= fill_cnt + CW'(1);
                        end
                    end
                end
                S_LAUNCH: begin
                    start_o <= 1'b0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (window_done) begin
                        state    <= S_FILL;
                        fill_cnt <= '0;
                        in_ready <= 1'b1;
                        busy_o   <= 1'b0;
                    end
                end
                default: begin
                    state    <= S_FILL;
                    idx      <= '0;
                    fill_cnt <= '0;
                    in_ready <= 1'b1;
                    start_o  <= 1'b0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule
